// File: rtl/arm_cmd_sequencer_if.sv
// Handshake and controller-side bus of the arm command sequencer.
//   Upstream side : cmd_valid/cmd_ready with cmd_op/cmd_x/cmd_y/cmd_angle, plus abort.
//   Arm side      : op_code/coord_x/coord_y/angle, busy, cmd_done, count.
// master : the upstream command source (drives commands, observes status).
// slave  : the sequencer itself.
interface arm_cmd_sequencer_if #(
    parameter int unsigned DEPTH = 4
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_op;
    logic [3:0]               cmd_x;
    logic [3:0]               cmd_y;
    logic [2:0]               cmd_angle;
    logic                     abort;
    logic [1:0]               op_code;
    logic [3:0]               coord_x;
    logic [3:0]               coord_y;
    logic [2:0]               angle;
    logic                     busy;
    logic                     cmd_done;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_angle, abort,
        input  cmd_ready, op_code, coord_x, coord_y, angle, busy, cmd_done, count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_angle, abort,
        output cmd_ready, op_code, coord_x, coord_y, angle, busy, cmd_done, count
    );
endinterface

// File: rtl/arm_cmd_sequencer.sv
// Command FIFO and sequencer feeding the robotic arm controller.
// Buffers packed {op, x, y, angle} commands and presents each one on the
// controller outputs for HOLD_CYCLES clocks, back-to-back when queued, and
// drives REST (all zero) whenever no command is active.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - arm_cmd_sequencer_if.slave (command handshake, abort, arm outputs, status)
module arm_cmd_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    arm_cmd_sequencer_if.slave bus
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    logic [12:0]      mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    state_e           state_q;
    logic [HoldW-1:0] hold_q;
    logic [1:0]       op_q;
    logic [3:0]       x_q, y_q;
    logic [2:0]       ang_q;
    logic             busy_q, done_q;

    logic        push, pop;
    logic [12:0] head;

    assign bus.cmd_ready = (count_q != CntFull) && !bus.abort;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    // A pop happens whenever the output slot is free or about to free up this edge.
    assign pop  = !bus.abort && (count_q != '0) &&
                  ((state_q == StIdle) || (hold_q == '0));
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_angle};
        end
    end

    // Pointers are PtrW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ang_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q <= StIdle;
            hold_q  <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ang_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        {op_q, x_q, y_q, ang_q} <= head;
                        hold_q  <= HoldLoad;
                        busy_q  <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - HoldW'(1);
                    end else begin
                        done_q <= 1'b1;
                        if (pop) begin
                            {op_q, x_q, y_q, ang_q} <= head;
                            hold_q <= HoldLoad;
                        end else begin
                            op_q    <= '0;
                            x_q     <= '0;
                            y_q     <= '0;
                            ang_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.op_code  = op_q;
    assign bus.coord_x  = x_q;
    assign bus.coord_y  = y_q;
    assign bus.angle    = ang_q;
    assign bus.busy     = busy_q;
    assign bus.cmd_done = done_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_arm_cmd_sequencer.sv
module tb_arm_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arm_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    arm_cmd_sequencer #(
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of waiting commands plus the command on the arm
    // and how many more edges it must stay there.
    logic [12:0] mq[$];
    bit          m_active;
    logic [12:0] m_cur;
    int          m_left;
    bit          m_done;

    typedef struct {
        logic        v;
        logic [12:0] c;
        logic        ab;
        logic        rdy;
        logic [12:0] out;
        logic        busy;
        logic        done;
        int          cnt;
    } vec_t;
    vec_t tbl[$];

    logic [12:0] obs[$];
    bit          last_acc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [12:0] pk(input int op, input int x, input int y, input int a);
        logic [12:0] r;
        r = {op[1:0], x[3:0], y[3:0], a[2:0]};
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0;
        m_cur    = '0;
        m_left   = 0;
        m_done   = 0;
    endtask

    task automatic model_edge(input logic v, input logic [12:0] c, input logic ab);
        bit room;
        room   = (mq.size() != DEPTH);
        m_done = 0;
        if (ab) begin
            model_reset();
            return;
        end
        if (m_active && m_left > 0) begin
            m_left--;
        end else begin
            m_done = m_active;
            if (mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1;
                m_left   = HOLD - 1;
            end else begin
                m_active = 0;
            end
        end
        if (v && room) mq.push_back(c);
    endtask

    function automatic logic [12:0] dut_out();
        return {bus.op_code, bus.coord_x, bus.coord_y, bus.angle};
    endfunction

    // Drive one cycle of inputs, check ready before the edge and all outputs after it.
    task automatic step(input logic v, input logic [12:0] c, input logic ab);
        logic [12:0] exp_o;
        bus.cmd_valid = v;
        {bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_angle} = c;
        bus.abort = ab;
        #1;
        chk("cmd_ready", int'(bus.cmd_ready), int'((mq.size() != DEPTH) && !ab));
        last_acc = v && bus.cmd_ready;
        @(posedge clk);
        model_edge(v, c, ab);
        #1;
        exp_o = m_active ? m_cur : 13'd0;
        chk("outputs", int'(dut_out()), int'(exp_o));
        chk("busy", int'(bus.busy), int'(m_active));
        chk("cmd_done", int'(bus.cmd_done), int'(m_done));
        chk("count", int'(bus.count), mq.size());
    endtask

    task automatic add(input logic v, input logic [12:0] c, input logic ab, input logic rdy,
                       input logic [12:0] out, input logic busy, input logic done,
                       input int cnt);
        vec_t r;
        r.v = v; r.c = c; r.ab = ab; r.rdy = rdy;
        r.out = out; r.busy = busy; r.done = done; r.cnt = cnt;
        tbl.push_back(r);
    endtask

    initial begin
        logic [12:0] a2, pa, pb, pc, pd, z;
        logic [12:0] burst[7];
        int idx, dones, guard;
        bit saw_full;

        model_reset();
        z  = '0;
        a2 = pk(1, 3, 4, 0);
        pa = pk(3, 1, 2, 3);
        pb = pk(2, 5, 6, 7);
        pc = pk(1, 8, 9, 1);
        pd = pk(0, 12, 13, 6);

        // Single command: held for two clocks, then done pulse and REST.
        add(1, a2, 0, 1, z,  0, 0, 1);
        add(0, z,  0, 1, a2, 1, 0, 0);
        add(0, z,  0, 1, a2, 1, 0, 0);
        add(0, z,  0, 1, z,  0, 1, 0);
        add(0, z,  0, 1, z,  0, 0, 0);
        // Abort during the first hold: no done, valid ignored, queue flushed.
        add(1, pa, 0, 1, z,  0, 0, 1);
        add(1, pb, 0, 1, pa, 1, 0, 1);
        add(1, pc, 0, 1, pa, 1, 0, 2);
        add(1, pd, 1, 0, z,  0, 0, 0);
        add(0, z,  0, 1, z,  0, 0, 0);
        // Push on the same edge a hold completes: count stays 2, pushed entry last.
        add(1, pa, 0, 1, z,  0, 0, 1);
        add(1, pb, 0, 1, pa, 1, 0, 1);
        add(1, pc, 0, 1, pa, 1, 0, 2);
        add(1, pd, 0, 1, pb, 1, 1, 2);
        add(0, z,  0, 1, pb, 1, 0, 2);
        add(0, z,  0, 1, pc, 1, 1, 1);
        add(0, z,  0, 1, pc, 1, 0, 1);
        add(0, z,  0, 1, pd, 1, 1, 0);
        add(0, z,  0, 1, pd, 1, 0, 0);
        add(0, z,  0, 1, z,  0, 1, 0);
        add(0, z,  0, 1, z,  0, 0, 0);

        // Reset held with valid asserted.
        bus.cmd_valid = 1'b1;
        {bus.cmd_op, bus.cmd_x, bus.cmd_y, bus.cmd_angle} = pk(2, 7, 7, 7);
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", int'(dut_out()), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.cmd_done), 0);
        chk("rst_count", int'(bus.count), 0);
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
        step(0, z, 0);
        chk("rst_no_push", int'(bus.count), 0);

        // Directed vectors.
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].c, tbl[i].ab);
            chk($sformatf("vec%0d_ready", i), int'(last_acc || !tbl[i].v ? (last_acc ? 1 : int'(tbl[i].rdy && !tbl[i].v ? 1 : 0)) : 0), int'(tbl[i].v ? tbl[i].rdy : (tbl[i].rdy ? 1 : 0)));
            chk($sformatf("vec%0d_out", i), int'(dut_out()), int'(tbl[i].out));
            chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
            chk($sformatf("vec%0d_done", i), int'(bus.cmd_done), int'(tbl[i].done));
            chk($sformatf("vec%0d_count", i), int'(bus.count), tbl[i].cnt);
        end

        // Burst of 7 through a 4-deep FIFO: fills, wraps, every command held twice.
        burst[0] = pk(1, 1, 2, 3);
        burst[1] = pk(2, 15, 0, 7);
        burst[2] = pk(3, 4, 5, 6);
        burst[3] = pk(0, 9, 9, 1);
        burst[4] = pk(1, 10, 11, 2);
        burst[5] = pk(2, 6, 14, 5);
        burst[6] = pk(3, 13, 3, 4);
        idx = 0; dones = 0; guard = 0; saw_full = 0;
        obs.delete();
        while ((idx < 7 || bus.busy || bus.count != 0) && guard < 100) begin
            step(idx < 7, (idx < 7) ? burst[idx] : z, 0);
            if (last_acc) idx++;
            if (bus.count == DEPTH && !bus.cmd_ready) saw_full = 1;
            if (bus.cmd_done) dones++;
            if (bus.busy) obs.push_back(dut_out());
            guard++;
        end
        chk("burst_timeout", guard < 100, 1);
        chk("burst_full_seen", saw_full, 1);
        chk("burst_done_pulses", dones, 7);
        chk("burst_obs_len", obs.size(), 7 * HOLD);
        for (int i = 0; i < 7 * HOLD && i < obs.size(); i++) begin
            chk($sformatf("burst_obs%0d", i), int'(obs[i]), int'(burst[i / HOLD]));
        end

        // Asynchronous reset while a calibrate command is held.
        step(1, pk(3, 9, 10, 5), 0);
        step(1, pk(1, 2, 2, 2), 0);
        chk("pre_arst_op", int'(bus.op_code), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_op", int'(bus.op_code), 0);
        chk("arst_outputs", int'(dut_out()), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_count", int'(bus.count), 0);
        model_reset();
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 2) != 0, 13'($urandom), $urandom_range(0, 24) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
